// File: rtl/onewire_pkg.sv
`timescale 1ns/1ps
// Shared 1-wire command encodings, FSM states and slot timing constants (microseconds).
// Timing values are the standard-speed 1-wire slot figures.
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_WAIT,
    BIT_LOW,
    BIT_WAIT
  } state_t;

  typedef enum logic {
    CMD_RST = 1'b0,
    CMD_BIT = 1'b1
  } cmd_typ_t;

  localparam int unsigned T_RST_LOW_US  = 480;
  localparam int unsigned T_RST_SMP_US  = 70;
  localparam int unsigned T_RST_WAIT_US = 480;
  localparam int unsigned T_W1_LOW_US   = 6;
  localparam int unsigned T_W0_LOW_US   = 60;
  localparam int unsigned T_BIT_SMP_US  = 15;
  localparam int unsigned T_SLOT_US     = 70;

  localparam int unsigned US_CNT_W = 9;
  typedef logic [US_CNT_W-1:0] us_cnt_t;

  // Counter value on the tick that completes the given interval.
  function automatic us_cnt_t us_last(input int unsigned us);
    return us_cnt_t'(us - 1);
  endfunction

endpackage

// File: rtl/onewire_if.sv
`timescale 1ns/1ps
// Command/response handshake plus per-port 1-wire line controls.
// master = command issuer and line model, slave = sequencer.
interface onewire_if #(
  parameter int PN = 2
);
  localparam int PW = (PN > 1) ? $clog2(PN) : 1;

  logic          cmd_vld;
  logic          cmd_rdy;
  logic          cmd_typ;
  logic          cmd_dat;
  logic [PW-1:0] cmd_prt;
  logic          cmd_pwr;
  logic          rsp_vld;
  logic          rsp_dat;
  logic [PN-1:0] owr_e;
  logic [PN-1:0] owr_p;
  logic [PN-1:0] owr_i;

  modport master (
    output cmd_vld, cmd_typ, cmd_dat, cmd_prt, cmd_pwr, owr_i,
    input  cmd_rdy, rsp_vld, rsp_dat, owr_e, owr_p
  );

  modport slave (
    input  cmd_vld, cmd_typ, cmd_dat, cmd_prt, cmd_pwr, owr_i,
    output cmd_rdy, rsp_vld, rsp_dat, owr_e, owr_p
  );
endinterface

// File: rtl/onewire_tick.sv
`timescale 1ns/1ps
// Microsecond prescaler: 1-cycle o_tick every CDR_N cycles; no backpressure.
// i_clr restarts the phase so slot timings are exact multiples of CDR_N from command accept.
module onewire_tick #(
  parameter int CDR_N = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int PW = (CDR_N > 1) ? $clog2(CDR_N) : 1;

  logic [PW-1:0] r_presc;
  logic          w_wrap;

  assign w_wrap = (r_presc == PW'(CDR_N - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (i_clr || w_wrap) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end
endmodule

// File: rtl/onewire_seq.sv
`timescale 1ns/1ps
// 1-wire reset/bit-slot sequencer over PN ports; one command in flight, cmd_rdy only when idle,
// rsp_vld strobes on return to idle. Strong pull-up after cmd_pwr commands needs ONEWIRE_PWR_EN.
module onewire_seq
  import onewire_pkg::*;
#(
  parameter int CDR_N = 24,
  parameter int PN    = 2
) (
  input logic      clk,
  input logic      reset_n,
  onewire_if.slave bus
);
  localparam int PW = (PN > 1) ? $clog2(PN) : 1;

  function automatic logic [PN-1:0] port_mask(input logic [PW-1:0] p);
    return PN'(1) << p;
  endfunction

  logic [PN-1:0] r_sync1;
  logic [PN-1:0] r_sync2;
  state_t        r_state;
  logic          r_rdy;
  us_cnt_t       r_us;
  logic [PW-1:0] r_prt;
  logic          r_dat;
  logic          r_smp;
  logic          r_rsp_vld;
  logic          r_rsp_dat;
  logic [PN-1:0] r_owr_e;
  logic          w_acc;
  logic          w_tick;
  logic          w_line;
  logic          w_done;
`ifdef ONEWIRE_PWR_EN
  logic          r_pwr;
  logic [PN-1:0] r_owr_p;
`else
  logic          w_unused_pwr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.owr_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_acc  = bus.cmd_vld & r_rdy;
  assign w_line = r_sync2[r_prt];
  assign w_done = w_tick &&
                  (((r_state == RST_WAIT) && (r_us == us_last(T_RST_WAIT_US))) ||
                   ((r_state == BIT_WAIT) && (r_us == us_last(T_SLOT_US))));

  onewire_tick #(.CDR_N(CDR_N)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_acc),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rdy     <= 1'b1;
      r_us      <= '0;
      r_prt     <= '0;
      r_dat     <= 1'b0;
      r_smp     <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= 1'b0;
      r_owr_e   <= '0;
`ifdef ONEWIRE_PWR_EN
      r_pwr     <= 1'b0;
      r_owr_p   <= '0;
`endif
    end else begin
      r_rsp_vld <= 1'b0;
      if (w_tick) r_us <= r_us + 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.cmd_vld) begin
            r_prt   <= bus.cmd_prt;
            r_dat   <= bus.cmd_dat;
            r_us    <= '0;
            r_rdy   <= 1'b0;
            r_owr_e <= port_mask(bus.cmd_prt);
            r_state <= (bus.cmd_typ == CMD_BIT) ? BIT_LOW : RST_LOW;
`ifdef ONEWIRE_PWR_EN
            r_pwr   <= bus.cmd_pwr;
            r_owr_p <= '0;
`endif
          end
        end
        RST_LOW: begin
          if (w_tick && (r_us == us_last(T_RST_LOW_US))) begin
            r_owr_e <= '0;
            r_us    <= '0;
            r_state <= RST_WAIT;
          end
        end
        RST_WAIT: begin
          // Presence pulse is active-low on the line.
          if (w_tick && (r_us == us_last(T_RST_SMP_US))) r_smp <= ~w_line;
        end
        BIT_LOW: begin
          // A write-0 still spans the sample point, so sampling can land in either state.
          if (w_tick && (r_us == us_last(T_BIT_SMP_US))) r_smp <= w_line;
          if (w_tick && (r_us == (r_dat ? us_last(T_W1_LOW_US) : us_last(T_W0_LOW_US)))) begin
            r_owr_e <= '0;
            r_state <= BIT_WAIT;
          end
        end
        BIT_WAIT: begin
          if (w_tick && (r_us == us_last(T_BIT_SMP_US))) r_smp <= w_line;
        end
        default: begin
          r_owr_e <= '0;
          r_state <= IDLE;
        end
      endcase
      if (w_done) begin
        r_state   <= IDLE;
        r_rdy     <= 1'b1;
        r_rsp_vld <= 1'b1;
        r_rsp_dat <= r_smp;
`ifdef ONEWIRE_PWR_EN
        r_owr_p   <= r_pwr ? port_mask(r_prt) : '0;
`endif
      end
    end
  end

  assign bus.cmd_rdy = r_rdy;
  assign bus.rsp_vld = r_rsp_vld;
  assign bus.rsp_dat = r_rsp_dat;
  assign bus.owr_e   = r_owr_e;
`ifdef ONEWIRE_PWR_EN
  assign bus.owr_p   = r_owr_p;
`else
  assign bus.owr_p   = '0;
  assign w_unused_pwr = bus.cmd_pwr;
`endif
endmodule

// File: tb/tb_onewire_seq.sv
`timescale 1ns/1ps
// Bench for onewire_seq: scoreboard of expected rsp_dat plus per-scenario timing checks.
module tb_onewire_seq;
  import onewire_pkg::*;

  localparam int CDR_N = 24;
  localparam int PN    = 2;
  localparam int US    = CDR_N;
`ifdef ONEWIRE_PWR_EN
  localparam bit PWR_EN = 1'b1;
`else
  localparam bit PWR_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [PN-1:0] dev_low = '0;
  int            n_pass  = 0;
  int            n_total = 0;
  int            cyc     = 0;
  int            acc_cyc = 0;
  bit            exp_q[$];

  onewire_if #(.PN(PN)) ow ();

  onewire_seq #(.CDR_N(CDR_N), .PN(PN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ow.slave)
  );

  // Open-drain line: low when the master or the device model pulls it.
  assign ow.owr_i = ~(ow.owr_e | dev_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ow.rsp_vld === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: rsp_vld=1 rsp_dat=%0b, required no response", ow.rsp_dat);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (ow.rsp_dat !== e) $display("FAIL rsp_dat: got %0b, required %0b", ow.rsp_dat, e);
        else n_pass++;
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (ow.cmd_rdy !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (ow.cmd_rdy !== 1'b1) $display("FAIL idle_timeout: cmd_rdy=%0b, required 1", ow.cmd_rdy);
    else n_pass++;
  endtask

  // Caller is at a negedge with cmd_rdy high; returns #1 after the accept edge.
  task automatic issue(input bit typ, input bit dat, input logic prt, input bit pwr, input bit exp);
    exp_q.push_back(exp);
    ow.cmd_vld = 1'b1;
    ow.cmd_typ = typ;
    ow.cmd_dat = dat;
    ow.cmd_prt = prt;
    ow.cmd_pwr = pwr;
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    ow.cmd_vld = 1'b0;
    ow.cmd_typ = 1'($urandom);
    ow.cmd_dat = 1'($urandom);
    ow.cmd_prt = 1'($urandom);
    ow.cmd_pwr = 1'($urandom);
  endtask

  task automatic wait_fall(input int p, input int max_cyc, output int lat, output bit other);
    lat = -1;
    other = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (ow.owr_e[1-p] !== 1'b0) other = 1'b1;
      if (ow.owr_e[p] !== 1'b1) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int p, input int max_cyc, output int lat, output bit other);
    lat = -1;
    other = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (ow.owr_e[1-p] !== 1'b0) other = 1'b1;
      if (ow.rsp_vld === 1'b1) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (ow.owr_e !== 2'b00) $display("FAIL rst_owr_e: got %b, required 00", ow.owr_e); else n_pass++;
    n_total++; if (ow.owr_p !== 2'b00) $display("FAIL rst_owr_p: got %b, required 00", ow.owr_p); else n_pass++;
    n_total++; if (ow.rsp_vld !== 1'b0) $display("FAIL rst_rsp_vld: got %b, required 0", ow.rsp_vld); else n_pass++;
    n_total++; if (ow.rsp_dat !== 1'b0) $display("FAIL rst_rsp_dat: got %b, required 0", ow.rsp_dat); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_total++; if (ow.cmd_rdy !== 1'b1) $display("FAIL rst_cmd_rdy: got %b, required 1", ow.cmd_rdy); else n_pass++;
  endtask

  task automatic test_presence();
    int lat_e, lat_r;
    bit oth_a, oth_b;
    @(negedge clk);
    wait_idle(10);
    issue(CMD_RST, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_fall(1, 12000, lat_e, oth_a);
    n_total++; if (lat_e != 11520) $display("FAIL pres_low_len: got %0d cycles, required 11520", lat_e); else n_pass++;
    // Presence pulse of 160 us starting 15 us after release.
    repeat (15*US) @(negedge clk);
    dev_low[1] = 1'b1;
    repeat (160*US) @(negedge clk);
    dev_low[1] = 1'b0;
    wait_rsp(1, 12000, lat_r, oth_b);
    n_total++; if (lat_r != 23040) $display("FAIL pres_rsp_lat: got %0d cycles, required 23040", lat_r); else n_pass++;
    n_total++; if (oth_a | oth_b) $display("FAIL pres_port0_idle: owr_e[0] seen=1, required 0"); else n_pass++;
  endtask

  task automatic test_no_device();
    int lat_e, lat_r;
    bit oth_a, oth_b;
    @(negedge clk);
    wait_idle(10);
    issue(CMD_RST, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_fall(1, 12000, lat_e, oth_a);
    wait_rsp(1, 12000, lat_r, oth_b);
    n_total++; if (lat_r != 23040) $display("FAIL nodev_rsp_lat: got %0d cycles, required 23040", lat_r); else n_pass++;
    n_total++; if (oth_a | oth_b) $display("FAIL nodev_port0_idle: owr_e[0] seen=1, required 0"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_rsp = 0;
    @(negedge clk);
    wait_idle(10);
    issue(CMD_RST, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (100*US) @(negedge clk);
    n_total++; if (ow.owr_e !== 2'b10) $display("FAIL mid_pre_owr_e: got %b, required 10", ow.owr_e); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (ow.owr_e !== 2'b00) $display("FAIL mid_owr_e: got %b, required 00", ow.owr_e); else n_pass++;
    n_total++; if (ow.owr_p !== 2'b00) $display("FAIL mid_owr_p: got %b, required 00", ow.owr_p); else n_pass++;
    exp_q.delete();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_total++; if (ow.cmd_rdy !== 1'b1) $display("FAIL mid_cmd_rdy: got %b, required 1", ow.cmd_rdy); else n_pass++;
    for (int i = 0; i < 400*US; i++) begin
      @(negedge clk);
      if (ow.rsp_vld === 1'b1 || ow.owr_e !== 2'b00) n_rsp++;
    end
    n_total++; if (n_rsp != 0) $display("FAIL mid_quiet: got %0d active cycles, required 0", n_rsp); else n_pass++;
  endtask

  task automatic test_write_b2b();
    int lat_e, lat_r;
    bit oth_a, oth_b;
    @(negedge clk);
    wait_idle(10);
    issue(CMD_BIT, 1'b0, 1'b0, 1'b0, 1'b0);
    // Junk requests while busy must be ignored.
    repeat (50) begin
      @(negedge clk);
      ow.cmd_vld = 1'b1;
      ow.cmd_typ = 1'($urandom);
      ow.cmd_dat = 1'($urandom);
      ow.cmd_prt = 1'($urandom);
    end
    ow.cmd_vld = 1'b0;
    wait_fall(0, 2000, lat_e, oth_a);
    n_total++; if (lat_e != 1440) $display("FAIL w0_low_len: got %0d cycles, required 1440", lat_e); else n_pass++;
    wait_rsp(0, 2000, lat_r, oth_b);
    n_total++; if (lat_r != 1680) $display("FAIL w0_slot_len: got %0d cycles, required 1680", lat_r); else n_pass++;
    n_total++; if (oth_a | oth_b) $display("FAIL w0_port1_idle: owr_e[1] seen=1, required 0"); else n_pass++;
    n_total++; if (ow.cmd_rdy !== 1'b1) $display("FAIL b2b_cmd_rdy: got %b, required 1", ow.cmd_rdy); else n_pass++;
    issue(CMD_BIT, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_fall(0, 2000, lat_e, oth_a);
    n_total++; if (lat_e != 144) $display("FAIL w1_low_len: got %0d cycles, required 144", lat_e); else n_pass++;
    wait_rsp(0, 2000, lat_r, oth_b);
    n_total++; if (lat_r != 1680) $display("FAIL w1_slot_len: got %0d cycles, required 1680", lat_r); else n_pass++;
  endtask

  task automatic test_read();
    int lat_r;
    bit oth;
    @(negedge clk);
    wait_idle(10);
    issue(CMD_BIT, 1'b1, 1'b0, 1'b0, 1'b0);
    dev_low[0] = 1'b1;
    repeat (30*US) @(negedge clk);
    dev_low[0] = 1'b0;
    wait_rsp(0, 2000, lat_r, oth);
    n_total++; if (lat_r != 1680) $display("FAIL rd0_slot_len: got %0d cycles, required 1680", lat_r); else n_pass++;
    @(negedge clk);
    wait_idle(10);
    issue(CMD_BIT, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_rsp(0, 2000, lat_r, oth);
    n_total++; if (lat_r != 1680) $display("FAIL rd1_slot_len: got %0d cycles, required 1680", lat_r); else n_pass++;
    // A device holding port 0 low must not affect a read on port 1.
    @(negedge clk);
    wait_idle(10);
    dev_low[0] = 1'b1;
    issue(CMD_BIT, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_rsp(1, 2000, lat_r, oth);
    dev_low[0] = 1'b0;
    n_total++; if (lat_r != 1680) $display("FAIL rdp1_slot_len: got %0d cycles, required 1680", lat_r); else n_pass++;
  endtask

  task automatic test_pwr();
    int lat_r;
    bit oth;
    logic [1:0] exp_p;
    exp_p = PWR_EN ? 2'b10 : 2'b00;
    @(negedge clk);
    wait_idle(10);
    n_total++; if (ow.owr_p !== 2'b00) $display("FAIL pwr_pre: got %b, required 00", ow.owr_p); else n_pass++;
    issue(CMD_BIT, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_rsp(1, 2000, lat_r, oth);
    n_total++; if (ow.owr_p !== exp_p) $display("FAIL pwr_on_rsp: got %b, required %b", ow.owr_p, exp_p); else n_pass++;
    n_total++; if ((ow.owr_e & ow.owr_p) !== 2'b00) $display("FAIL pwr_excl: owr_e=%b owr_p=%b, required no overlap", ow.owr_e, ow.owr_p); else n_pass++;
    repeat (20) @(negedge clk);
    n_total++; if (ow.owr_p !== exp_p) $display("FAIL pwr_hold: got %b, required %b", ow.owr_p, exp_p); else n_pass++;
    issue(CMD_BIT, 1'b1, 1'b0, 1'b0, 1'b1);
    n_total++; if (ow.owr_p !== 2'b00) $display("FAIL pwr_off_acc: got %b, required 00", ow.owr_p); else n_pass++;
    wait_rsp(0, 2000, lat_r, oth);
    n_total++; if (ow.owr_p !== 2'b00) $display("FAIL pwr_no_req: got %b, required 00", ow.owr_p); else n_pass++;
  endtask

  initial begin
    ow.cmd_vld = 1'b0;
    ow.cmd_typ = 1'b0;
    ow.cmd_dat = 1'b0;
    ow.cmd_prt = 1'b0;
    ow.cmd_pwr = 1'b0;
    test_reset();
    test_presence();
    test_no_device();
    test_reset_mid();
    test_write_b2b();
    test_read();
    test_pwr();
    repeat (5) @(negedge clk);
    n_total++; if (exp_q.size() != 0) $display("FAIL sb_drain: %0d responses missing, required 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
